// File: rtl/axis_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_frame_gen
//
// Purpose:
//   Length-driven AXI-stream frame source. A length command is accepted and
//   one frame of exactly that many bytes (or beats when KEEP_ENABLE=0) is
//   emitted on the AXI-stream master. The frame is split into
//   DATA_WIDTH-wide beats with tkeep and tlast set on the final beat.
//
// Build option:
//   AXIS_FRAME_GEN_PATTERN_EN - when defined, tdata byte lane k carries
//   (frame byte offset + k) mod 256. When undefined, every valid tdata byte
//   is 0x00 and no offset counter exists.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   s_len          in   frame length command (bytes, or beats if KEEP_ENABLE=0)
//   s_len_valid    in   command valid
//   s_len_ready    out  command accepted when valid && ready
//   m_axis_tdata   out  payload
//   m_axis_tkeep   out  byte enables, lane 0 = bits [7:0]
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  final beat of frame
//   busy           out  high while a frame is being sent
// ---------------------------------------------------------------------------
module axis_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic                  s_len_valid,
  output logic                  s_len_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Amount consumed from the remaining count per transferred beat: a full
  // beat of bytes, or a single beat when lengths are counted in beats.
  localparam logic [LEN_WIDTH-1:0] STEP =
    (KEEP_ENABLE != 0) ? LEN_WIDTH'(KEEP_WIDTH) : LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;

`ifdef AXIS_FRAME_GEN_PATTERN_EN
  localparam logic [7:0] OFFSET_STEP = 8'(KEEP_WIDTH);
  // Only the low byte of the frame offset matters since lanes wrap mod 256.
  logic [7:0] offset_q, offset_d;
`endif

  logic last_beat;
  logic beat_xfer;
  logic cmd_accept;
  logic cmd_nonzero;

  // All outputs are decoded from the registered state and remaining count,
  // so they stay stable for free while the sink stalls.
  assign last_beat     = (state_q == SEND) && (rem_q <= STEP);
  assign beat_xfer     = (state_q == SEND) && m_axis_tready;
  // Ready combinationally follows tready on the last beat so a new command
  // can be taken in the same cycle and frames run back-to-back.
  assign s_len_ready   = (state_q == IDLE) || (beat_xfer && last_beat);
  assign cmd_accept    = s_len_valid && s_len_ready;
  assign cmd_nonzero   = (s_len != '0);
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = last_beat;
  assign busy          = (state_q == SEND);

  // Next-state logic. A zero-length command is accepted but never loads the
  // counter, so it is silently dropped; when it arrives on a last beat the
  // frame simply ends and the FSM returns to IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
    offset_d = offset_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_accept && cmd_nonzero) begin
          state_d = SEND;
          rem_d   = s_len;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
          offset_d = '0;
`endif
        end
      end
      SEND: begin
        if (beat_xfer) begin
          if (last_beat) begin
            if (cmd_accept && cmd_nonzero) begin
              state_d = SEND;
              rem_d   = s_len;
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
`ifdef AXIS_FRAME_GEN_PATTERN_EN
            offset_d = '0;
`endif
          end else begin
            rem_d = rem_q - STEP;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
            offset_d = offset_q + OFFSET_STEP;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame discards the
  // remaining count so no partial frame survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
      offset_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
      offset_q <= offset_d;
`endif
    end
  end

  // Lane k is enabled while more than k units remain, which yields all-ones
  // for full beats and the low rem bits on the final beat. Disabled lanes
  // and the IDLE state drive zero data.
  always_comb begin
    m_axis_tkeep = '0;
    m_axis_tdata = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      if (KEEP_ENABLE != 0) begin
        m_axis_tkeep[k] = (state_q == SEND) && (rem_q > LEN_WIDTH'(k));
      end else begin
        m_axis_tkeep[k] = 1'b1;
      end
`ifdef AXIS_FRAME_GEN_PATTERN_EN
      if ((state_q == SEND) && m_axis_tkeep[k]) begin
        m_axis_tdata[8*k +: 8] = offset_q + 8'(k);
      end
`endif
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_gen
//
// Directed bench for axis_frame_gen (DATA_WIDTH=64). Each command pushes
// its expected beats and frame length into scoreboard queues; a negedge
// monitor pops and compares every transferred beat, checks that stalled
// beats hold steady, and totals the bytes of each frame.
// ---------------------------------------------------------------------------
module tb_axis_frame_gen;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [15:0] s_len;
  logic        s_len_valid;
  logic        s_len_ready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;

  beat_t sb_q[$];
  int    len_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        hold_pending = 1'b0;
  logic [63:0] hold_data;
  logic [7:0]  hold_keep;
  logic        hold_last;
  int          frame_bytes = 0;

  axis_frame_gen #(
    .DATA_WIDTH (64),
    .LEN_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_len         (s_len),
    .s_len_valid   (s_len_valid),
    .s_len_ready   (s_len_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence itself ever stalls.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: builds the beats a frame of len bytes must produce.
  task automatic pushFrame(input int len);
    int remaining = len;
    int off = 0;
    while (remaining > 0) begin
      beat_t b;
      b = '0;
      for (int k = 0; k < 8; k++) begin
        if (k < remaining) begin
          b.keep[k] = 1'b1;
`ifdef AXIS_FRAME_GEN_PATTERN_EN
          b.data[8*k +: 8] = 8'((off + k) % 256);
`endif
        end
      end
      b.last = (remaining <= 8);
      sb_q.push_back(b);
      remaining -= 8;
      off += 8;
    end
    if (len > 0) len_q.push_back(len);
  endtask

  // Waits for command ready, offers one command and returns #1 after the
  // accepting edge, which is where the first beat must already be visible.
  task automatic applyStimulus(input int len);
    int n = 0;
    while (!s_len_ready && n < 20000) begin
      stepCycle();
      n++;
    end
    checkOutput("cmd_ready_wait", s_len_ready, 1'b1);
    s_len       = 16'(len);
    s_len_valid = 1'b1;
    pushFrame(len);
    stepCycle();
    s_len_valid = 1'b0;
    s_len       = '0;
  endtask

  task automatic drainIdle(input int budget);
    int n = 0;
    while ((m_axis_tvalid || sb_q.size() != 0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_in_budget", n < budget, 1'b1);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
  endtask

  // Beat monitor, sampling mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      frame_bytes  = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_tvalid", m_axis_tvalid, 1'b1);
        checkOutput("hold_tdata", m_axis_tdata, hold_data);
        checkOutput("hold_tkeep", m_axis_tkeep, hold_keep);
        checkOutput("hold_tlast", m_axis_tlast, hold_last);
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      hold_data    = m_axis_tdata;
      hold_keep    = m_axis_tkeep;
      hold_last    = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        checkOutput("beat_expected", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          beat_t e;
          e = sb_q.pop_front();
          checkOutput("beat_tdata", m_axis_tdata, e.data);
          checkOutput("beat_tkeep", m_axis_tkeep, e.keep);
          checkOutput("beat_tlast", m_axis_tlast, e.last);
          frame_bytes += $countones(m_axis_tkeep);
          if (m_axis_tlast) begin
            if (len_q.size() > 0) begin
              checkOutput("frame_len", frame_bytes, len_q.pop_front());
            end
            frame_bytes = 0;
          end
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    s_len         = '0;
    s_len_valid   = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) stepCycle();

    // Reset state
    checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("rst_tlast", m_axis_tlast, 1'b0);
    checkOutput("rst_tkeep", m_axis_tkeep, 8'h00);
    checkOutput("rst_tdata", m_axis_tdata, 64'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", s_len_ready, 1'b1);
    rst = 1'b0;
    stepCycle();

    // len=16: two full beats, ready returns on the last-beat cycle
    applyStimulus(16);
    checkOutput("l16_b0_tvalid", m_axis_tvalid, 1'b1);
    checkOutput("l16_b0_busy", busy, 1'b1);
    checkOutput("l16_b0_ready", s_len_ready, 1'b0);
    checkOutput("l16_b0_tlast", m_axis_tlast, 1'b0);
    stepCycle();
    checkOutput("l16_b1_tlast", m_axis_tlast, 1'b1);
    checkOutput("l16_b1_ready", s_len_ready, 1'b1);
    stepCycle();
    checkOutput("l16_done_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("l16_done_busy", busy, 1'b0);
    drainIdle(20);

    // len=13: partial final beat
    applyStimulus(13);
    drainIdle(20);

    // len=1: single beat
    applyStimulus(1);
    checkOutput("l1_tkeep", m_axis_tkeep, 8'h01);
    checkOutput("l1_tlast", m_axis_tlast, 1'b1);
    drainIdle(20);

    // len=0: accepted and dropped
    applyStimulus(0);
    checkOutput("l0_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("l0_busy", busy, 1'b0);
    stepCycle();
    checkOutput("l0_tvalid_later", m_axis_tvalid, 1'b0);
    checkOutput("l0_ready", s_len_ready, 1'b1);

    // Back-to-back len=8 commands with valid held
    s_len       = 16'd8;
    s_len_valid = 1'b1;
    pushFrame(8);
    stepCycle();
    checkOutput("b2b_f0_tvalid", m_axis_tvalid, 1'b1);
    checkOutput("b2b_f0_tlast", m_axis_tlast, 1'b1);
    checkOutput("b2b_f0_ready", s_len_ready, 1'b1);
    pushFrame(8);
    stepCycle();
    s_len_valid = 1'b0;
    checkOutput("b2b_f1_tvalid", m_axis_tvalid, 1'b1);
    checkOutput("b2b_f1_tlast", m_axis_tlast, 1'b1);
    stepCycle();
    checkOutput("b2b_end_tvalid", m_axis_tvalid, 1'b0);
    drainIdle(20);

    // len=24 with the sink stalling three cycles on the second beat
    applyStimulus(24);
    stepCycle();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("stall_tvalid", m_axis_tvalid, 1'b1);
      checkOutput("stall_ready", s_len_ready, 1'b0);
    end
    m_axis_tready = 1'b1;
    drainIdle(20);

    // Maximum length: 8192 beats ending with tkeep=0x7F
    applyStimulus(65535);
    drainIdle(9000);

    // Maximum length again, reset on beat 100 truncates the frame
    applyStimulus(65535);
    repeat (99) stepCycle();
    checkOutput("trunc_pre_tvalid", m_axis_tvalid, 1'b1);
    rst = 1'b1;
    stepCycle();
    checkOutput("trunc_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("trunc_tlast", m_axis_tlast, 1'b0);
    checkOutput("trunc_tkeep", m_axis_tkeep, 8'h00);
    checkOutput("trunc_ready", s_len_ready, 1'b1);
    checkOutput("trunc_busy", busy, 1'b0);
    sb_q.delete();
    len_q.delete();
    rst = 1'b0;
    repeat (3) stepCycle();
    checkOutput("post_rst_tvalid", m_axis_tvalid, 1'b0);

    // A short frame after the truncation starts cleanly
    applyStimulus(13);
    drainIdle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
